// File: rtl/spike_generator_array.sv
// Time-multiplexed bank of periodic spike generators. Each time_unit pulse sweeps
// generators 0..gens_used and emits one {tag, ct=1} word per expiring countdown.
module spike_generator_array #(
    parameter int Ngens   = 8,
    parameter int Nperiod = 16,
    parameter int Ntag    = 11,
    parameter int Nct     = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  time_unit,
    input  logic [Ngens-1:0]      gens_used,
    input  logic [2**Ngens-1:0]   gens_en,
    input  logic [Ngens-1:0]      prog_gen_idx,
    input  logic [Nperiod-1:0]    prog_period,
    input  logic [Nperiod-1:0]    prog_ticks,
    input  logic [Ntag-1:0]       prog_tag,
    input  logic                  prog_v,
    output logic                  prog_a,
    output logic [Ntag-1:0]       out_tag,
    output logic [Nct-1:0]        out_ct,
    output logic                  out_v,
    input  logic                  out_a,
    output logic                  missed_unit,
    output logic [1:0]            dbg_state
);

    localparam int Nent = 2**Ngens;

    // Handshake: a word moves on any cycle where v && a. out_v/out_tag are
    // registered and hold until out_a; out_v never depends on out_a combinationally.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [Ngens:0]       idx, idx_d;
    logic                 pending, pending_d;
    logic                 missed_d;
    logic                 out_v_d;
    logic [Ntag-1:0]      out_tag_d;

    logic [Nperiod-1:0]   period_mem [Nent];
    logic [Nperiod-1:0]   ticks_mem  [Nent];
    logic [Ntag-1:0]      tag_mem    [Nent];

    logic [Ngens-1:0]     ent;
    logic [Nperiod-1:0]   cur_period;
    logic [Nperiod-1:0]   cur_ticks;
    logic [Ntag-1:0]      cur_tag;
    logic                 in_range;
    logic                 active;
    logic                 fire;
    logic                 ticks_we;
    logic [Nperiod-1:0]   ticks_wdata;

    assign ent        = idx[Ngens-1:0];
    assign cur_period = period_mem[ent];
    assign cur_ticks  = ticks_mem[ent];
    assign cur_tag    = tag_mem[ent];
    assign in_range   = (idx <= {1'b0, gens_used});
    assign active     = gens_en[ent] && (cur_period != '0);
    assign fire       = (cur_ticks <= Nperiod'(1));

    // A same-cycle time_unit wins over programming, so the write waits.
    assign prog_a    = !reset && (state == IDLE) && prog_v && !time_unit;
    assign out_ct    = Nct'(1);
    assign dbg_state = state;

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        pending_d   = pending;
        missed_d    = missed_unit;
        out_v_d     = out_v;
        out_tag_d   = out_tag;
        ticks_we    = 1'b0;
        ticks_wdata = cur_ticks - Nperiod'(1);

        // One-deep pulse buffer while busy; a second pulse is lost.
        if (time_unit && (state != IDLE)) begin
            if (pending) missed_d = 1'b1;
            else         pending_d = 1'b1;
        end

        case (state)
            IDLE: begin
                if (time_unit || pending) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = SWEEP;
                end
            end
            SWEEP: begin
                if (!in_range) begin
                    state_d = IDLE;
                end else if (!active) begin
                    idx_d = idx + (Ngens+1)'(1);
                end else if (fire) begin
                    ticks_we    = 1'b1;
                    ticks_wdata = cur_period;
                    out_tag_d   = cur_tag;
                    out_v_d     = 1'b1;
                    state_d     = EMIT;
                end else begin
                    ticks_we = 1'b1;
                    idx_d    = idx + (Ngens+1)'(1);
                end
            end
            EMIT: begin
                if (out_a) begin
                    out_v_d = 1'b0;
                    idx_d   = idx + (Ngens+1)'(1);
                    state_d = SWEEP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            pending     <= 1'b0;
            missed_unit <= 1'b0;
            out_v       <= 1'b0;
            out_tag     <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            pending     <= pending_d;
            missed_unit <= missed_d;
            out_v       <= out_v_d;
            out_tag     <= out_tag_d;
        end
    end

    // Generator table is deliberately not reset; programming and sweep updates
    // never coincide because they live in different states.
    always_ff @(posedge clk) begin
        if (prog_a) begin
            period_mem[prog_gen_idx] <= prog_period;
            ticks_mem[prog_gen_idx]  <= prog_ticks;
            tag_mem[prog_gen_idx]    <= prog_tag;
        end else if (ticks_we) begin
            ticks_mem[ent] <= ticks_wdata;
        end
    end

endmodule
